video_frame_checker: RTL and testbench

VIDEO_FRAME_CHECKER -- requirements
Module: video_frame_checker

---
 rtl/video_frame_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_video_frame_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/video_frame_checker.sv
// video_frame_checker: measures incoming video timing and pixel data frame by
// frame and flags frames whose geometry differs from the expected resolution.
// Ports:
//   pixel_clock_i, reset_i (sync, active-high)     - clock / reset
//   check_en_i, link_i                             - enable, 0=1 pix/clk 1=2 pix/clk
//   vsync_i, hsync_i, data_valid_i, data{0,1}_{r,g,b}_i - video input
//   frame_done_o, frame_err_o, err_sticky_o        - per-frame result and history
//   h_active_o, v_active_o, h_total_o, frame_count_o, frame_checksum_o, locked_o
module video_frame_checker #(
  parameter int unsigned HOR_RESOLUTION = 1366,
  parameter int unsigned VER_RESOLUTION = 768,
  parameter              HSYNC_POL      = "NEGATIVE",
  parameter              VSYNC_POL      = "NEGATIVE"
) (
  input  logic        pixel_clock_i,
  input  logic        reset_i,
  input  logic        check_en_i,
  input  logic        link_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        data_valid_i,
  input  logic [7:0]  data0_r_i,
  input  logic [7:0]  data0_g_i,
  input  logic [7:0]  data0_b_i,
  input  logic [7:0]  data1_r_i,
  input  logic [7:0]  data1_g_i,
  input  logic [7:0]  data1_b_i,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic        err_sticky_o,
  output logic [15:0] h_active_o,
  output logic [15:0] v_active_o,
  output logic [15:0] h_total_o,
  output logic [15:0] frame_count_o,
  output logic [31:0] frame_checksum_o,
  output logic        locked_o
);

  localparam int unsigned CW = 16;
  localparam int unsigned SW = 32;
  localparam int unsigned PW = 24;
  localparam logic [CW-1:0] HOR_EXP = CW'(HOR_RESOLUTION);
  localparam logic [CW-1:0] VER_EXP = CW'(VER_RESOLUTION);
  // Syncs are stored normalised: 1 always means "active".
  localparam logic HS_INV = (HSYNC_POL != "POSITIVE");
  localparam logic VS_INV = (VSYNC_POL != "POSITIVE");

  typedef enum logic [1:0] {IDLE, SYNC_WAIT, ACTIVE} state_e;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + (CW+1)'(b);
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  state_e          state_q, state_d;
  logic            vs_q, vs_d, hs_q, hs_d, dv_q, dv_d, link_q, link_d;
  logic            vs_dly_q, vs_dly_d, hs_dly_q, hs_dly_d, dv_dly_q, dv_dly_d;
  logic [PW-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic [CW-1:0]   line_cnt_q, line_cnt_d, v_cnt_q, v_cnt_d, last_h_q, last_h_d;
  logic [CW-1:0]   h_cnt_q, h_cnt_d, h_meas_q, h_meas_d;
  logic            h_seen_q, h_seen_d, err_q, err_d, link_ref_q, link_ref_d;
  logic [SW-1:0]   chk_q, chk_d;
  logic [1:0]      good_cnt_q, good_cnt_d;
  logic            frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic            err_sticky_q, err_sticky_d, locked_q, locked_d;
  logic [CW-1:0]   h_active_q, h_active_d, v_active_q, v_active_d;
  logic [CW-1:0]   h_total_q, h_total_d, frame_count_q, frame_count_d;
  logic [SW-1:0]   frame_checksum_q, frame_checksum_d;

  logic            vs_edge, hs_edge, close_line, line_bad, link_bad, frame_bad;
  logic            start_frame, accumulate;
  logic [1:0]      pix_inc;
  logic [SW-1:0]   pix_sum;
  logic [CW-1:0]   v_close, h_last_close;

  // Input capture stage plus one delayed copy for edge detection.
  always_comb begin
    vs_d     = vsync_i ^ VS_INV;
    hs_d     = hsync_i ^ HS_INV;
    dv_d     = data_valid_i;
    link_d   = link_i;
    d0_d     = {data0_r_i, data0_g_i, data0_b_i};
    d1_d     = {data1_r_i, data1_g_i, data1_b_i};
    vs_dly_d = vs_q;
    hs_dly_d = hs_q;
    dv_dly_d = dv_q;
  end

  assign vs_edge  = vs_q & ~vs_dly_q;
  assign hs_edge  = hs_q & ~hs_dly_q;
  assign pix_inc  = dv_q ? (link_q ? 2'd2 : 2'd1) : 2'd0;
  assign pix_sum  = dv_q ? (link_q ? SW'(d0_q) + SW'(d1_q) : SW'(d0_q)) : '0;
  // A line ends on data_valid falling, or is forced closed by the vsync edge.
  assign close_line   = dv_dly_q & (~dv_q | vs_edge);
  assign line_bad     = close_line & (line_cnt_q != HOR_EXP);
  assign link_bad     = link_q != link_ref_q;
  assign v_close      = close_line ? sat_add(v_cnt_q, 2'd1) : v_cnt_q;
  assign h_last_close = close_line ? line_cnt_q : last_h_q;
  assign frame_bad    = err_q | line_bad | (v_close != VER_EXP);

  // Control, accumulation and result publication.
  always_comb begin
    state_d          = state_q;
    line_cnt_d       = line_cnt_q;
    v_cnt_d          = v_cnt_q;
    last_h_d         = last_h_q;
    h_cnt_d          = hs_edge ? CW'(1) : sat_add(h_cnt_q, 2'd1);
    h_seen_d         = h_seen_q | hs_edge;
    h_meas_d         = h_meas_q;
    chk_d            = chk_q;
    err_d            = err_q;
    link_ref_d       = link_ref_q;
    good_cnt_d       = good_cnt_q;
    frame_done_d     = 1'b0;
    frame_err_d      = frame_err_q;
    err_sticky_d     = err_sticky_q;
    locked_d         = locked_q;
    h_active_d       = h_active_q;
    v_active_d       = v_active_q;
    h_total_d        = h_total_q;
    frame_count_d    = frame_count_q;
    frame_checksum_d = frame_checksum_q;
    start_frame      = 1'b0;
    accumulate       = 1'b0;

    case (state_q)
      IDLE: begin
        locked_d   = 1'b0;
        good_cnt_d = '0;
        if (check_en_i) state_d = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        locked_d   = 1'b0;
        good_cnt_d = '0;
        if (!check_en_i) begin
          state_d = IDLE;
        end else if (vs_edge) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (!check_en_i) begin
          state_d    = IDLE;
          locked_d   = 1'b0;
          good_cnt_d = '0;
        end else if (vs_edge) begin
          frame_done_d     = 1'b1;
          frame_err_d      = frame_bad;
          err_sticky_d     = err_sticky_q | frame_bad;
          h_active_d       = h_last_close;
          v_active_d       = v_close;
          h_total_d        = h_meas_q;
          frame_checksum_d = chk_q;
          frame_count_d    = frame_count_q + CW'(1);
          good_cnt_d       = frame_bad ? 2'd0 : ((good_cnt_q == 2'd2) ? 2'd2 : good_cnt_q + 2'd1);
          locked_d         = ~frame_bad & (good_cnt_q != 2'd0);
          start_frame      = 1'b1;
        end else begin
          accumulate = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The cycle carrying the vsync edge already belongs to the new frame.
    if (start_frame) begin
      line_cnt_d = CW'(pix_inc);
      v_cnt_d    = '0;
      last_h_d   = '0;
      chk_d      = pix_sum;
      err_d      = 1'b0;
      link_ref_d = link_q;
      h_meas_d   = (hs_edge & h_seen_q) ? h_cnt_q : '0;
    end

    if (accumulate) begin
      line_cnt_d = close_line ? '0 : sat_add(line_cnt_q, pix_inc);
      v_cnt_d    = v_close;
      last_h_d   = h_last_close;
      chk_d      = chk_q + pix_sum;
      err_d      = err_q | line_bad | link_bad;
      if (hs_edge & h_seen_q) h_meas_d = h_cnt_q;
    end
  end

  always_ff @(posedge pixel_clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      vs_q <= 1'b0; hs_q <= 1'b0; dv_q <= 1'b0; link_q <= 1'b0;
      vs_dly_q <= 1'b0; hs_dly_q <= 1'b0; dv_dly_q <= 1'b0;
      d0_q <= '0; d1_q <= '0;
      line_cnt_q <= '0; v_cnt_q <= '0; last_h_q <= '0;
      h_cnt_q <= '0; h_meas_q <= '0; h_seen_q <= 1'b0;
      chk_q <= '0; err_q <= 1'b0; link_ref_q <= 1'b0; good_cnt_q <= '0;
      frame_done_q <= 1'b0; frame_err_q <= 1'b0; err_sticky_q <= 1'b0; locked_q <= 1'b0;
      h_active_q <= '0; v_active_q <= '0; h_total_q <= '0; frame_count_q <= '0;
      frame_checksum_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q <= vs_d; hs_q <= hs_d; dv_q <= dv_d; link_q <= link_d;
      vs_dly_q <= vs_dly_d; hs_dly_q <= hs_dly_d; dv_dly_q <= dv_dly_d;
      d0_q <= d0_d; d1_q <= d1_d;
      line_cnt_q <= line_cnt_d; v_cnt_q <= v_cnt_d; last_h_q <= last_h_d;
      h_cnt_q <= h_cnt_d; h_meas_q <= h_meas_d; h_seen_q <= h_seen_d;
      chk_q <= chk_d; err_q <= err_d; link_ref_q <= link_ref_d; good_cnt_q <= good_cnt_d;
      frame_done_q <= frame_done_d; frame_err_q <= frame_err_d;
      err_sticky_q <= err_sticky_d; locked_q <= locked_d;
      h_active_q <= h_active_d; v_active_q <= v_active_d; h_total_q <= h_total_d;
      frame_count_q <= frame_count_d; frame_checksum_q <= frame_checksum_d;
    end
  end

  assign frame_done_o     = frame_done_q;
  assign frame_err_o      = frame_err_q;
  assign err_sticky_o     = err_sticky_q;
  assign h_active_o       = h_active_q;
  assign v_active_o       = v_active_q;
  assign h_total_o        = h_total_q;
  assign frame_count_o    = frame_count_q;
  assign frame_checksum_o = frame_checksum_q;
  assign locked_o         = locked_q;

endmodule

// File: tb/tb_video_frame_checker.sv
// Directed bench for video_frame_checker: 8x4 frames driven into a
// negative-polarity and a positive-polarity instance with identical timing.
module tb_video_frame_checker;

  localparam int NLINES = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, link, vs_a, hs_a, dv;
  logic [23:0] d0, d1;

  logic        fd_n, fe_n, es_n, lk_n, fd_p, fe_p, es_p, lk_p;
  logic [15:0] ha_n, va_n, ht_n, fc_n, ha_p, va_p, ht_p, fc_p;
  logic [31:0] cs_n, cs_p;

  int errors = 0;
  int checks = 0;

  video_frame_checker #(.HOR_RESOLUTION(8), .VER_RESOLUTION(4),
                        .HSYNC_POL("NEGATIVE"), .VSYNC_POL("NEGATIVE")) dut_n (
    .pixel_clock_i(clk), .reset_i(rst), .check_en_i(en), .link_i(link),
    .vsync_i(~vs_a), .hsync_i(~hs_a), .data_valid_i(dv),
    .data0_r_i(d0[23:16]), .data0_g_i(d0[15:8]), .data0_b_i(d0[7:0]),
    .data1_r_i(d1[23:16]), .data1_g_i(d1[15:8]), .data1_b_i(d1[7:0]),
    .frame_done_o(fd_n), .frame_err_o(fe_n), .err_sticky_o(es_n),
    .h_active_o(ha_n), .v_active_o(va_n), .h_total_o(ht_n), .frame_count_o(fc_n),
    .frame_checksum_o(cs_n), .locked_o(lk_n));

  video_frame_checker #(.HOR_RESOLUTION(8), .VER_RESOLUTION(4),
                        .HSYNC_POL("POSITIVE"), .VSYNC_POL("POSITIVE")) dut_p (
    .pixel_clock_i(clk), .reset_i(rst), .check_en_i(en), .link_i(link),
    .vsync_i(vs_a), .hsync_i(hs_a), .data_valid_i(dv),
    .data0_r_i(d0[23:16]), .data0_g_i(d0[15:8]), .data0_b_i(d0[7:0]),
    .data1_r_i(d1[23:16]), .data1_g_i(d1[15:8]), .data1_b_i(d1[7:0]),
    .frame_done_o(fd_p), .frame_err_o(fe_p), .err_sticky_o(es_p),
    .h_active_o(ha_p), .v_active_o(va_p), .h_total_o(ht_p), .frame_count_o(fc_p),
    .frame_checksum_o(cs_p), .locked_o(lk_p));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with logical (active-high) sync levels.
  task automatic drive(input int v, input int h, input int d);
    vs_a = (v != 0);
    hs_a = (h != 0);
    dv   = (d != 0);
    tick();
  endtask

  // Line: hsync 1 clk, 2 blank, n valid clocks, 3 blank -> period n+6.
  task automatic line(input int n);
    drive(0, 1, 0);
    repeat (2) drive(0, 0, 0);
    repeat (n) drive(0, 0, 1);
    repeat (3) drive(0, 0, 0);
  endtask

  task automatic frame(input int n, input int short_line, input int glitch);
    for (int i = 0; i < NLINES; i++) begin
      line((i == short_line) ? n - 1 : n);
      if (glitch != 0 && i == 1) begin
        link = ~link;
        drive(0, 0, 0);
        link = ~link;
      end
    end
  endtask

  // vsync active for cycles N and N+1; frame_done expected only in N+2.
  task automatic pulse(input string tag, input int exp_done, input int new_link);
    link = (new_link != 0);
    drive(1, 0, 0);
    check_eq({tag, "_done_early"}, 32'(fd_n), 32'(0));
    drive(1, 0, 0);
    check_eq({tag, "_done_n"}, 32'(fd_n), 32'(exp_done));
    check_eq({tag, "_done_p"}, 32'(fd_p), 32'(exp_done));
    drive(0, 0, 0);
    check_eq({tag, "_done_late"}, 32'(fd_n), 32'(0));
  endtask

  task automatic chk_frame(input string tag, input int sel_p, input int cnt, input int err,
                           input int ha, input int va, input int cs, input int ht,
                           input int lk, input int sticky);
    check_eq({tag, "_count"},    32'(sel_p != 0 ? fc_p : fc_n), 32'(cnt));
    check_eq({tag, "_err"},      32'(sel_p != 0 ? fe_p : fe_n), 32'(err));
    check_eq({tag, "_h_active"}, 32'(sel_p != 0 ? ha_p : ha_n), 32'(ha));
    check_eq({tag, "_v_active"}, 32'(sel_p != 0 ? va_p : va_n), 32'(va));
    check_eq({tag, "_checksum"}, sel_p != 0 ? cs_p : cs_n,      32'(cs));
    check_eq({tag, "_h_total"},  32'(sel_p != 0 ? ht_p : ht_n), 32'(ht));
    check_eq({tag, "_locked"},   32'(sel_p != 0 ? lk_p : lk_n), 32'(lk));
    check_eq({tag, "_sticky"},   32'(sel_p != 0 ? es_p : es_n), 32'(sticky));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; link = 1'b0; vs_a = 1'b0; hs_a = 1'b0; dv = 1'b0;
    d0 = 24'h000001; d1 = 24'h000002;
    repeat (3) tick();
    check_eq("rst_done", 32'(fd_n), 32'(0));
    chk_frame("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0; en = 1'b1;
    repeat (3) drive(0, 0, 0);
    pulse("p1", 0, 0);

    // Single-pixel link, three good frames.
    frame(8, -1, 0); pulse("p2", 1, 0); chk_frame("fA", 0, 1, 0, 8, 4, 32, 14, 0, 0);
    frame(8, -1, 0); pulse("p3", 1, 0); chk_frame("fB", 0, 2, 0, 8, 4, 32, 14, 1, 0);
    frame(8, -1, 0); pulse("p4", 1, 0); chk_frame("fC", 0, 3, 0, 8, 4, 32, 14, 1, 0);

    // Short second line; link switches to dual at the closing vsync.
    frame(8, 1, 0);  pulse("p5", 1, 1); chk_frame("fD", 0, 4, 1, 8, 4, 31, 14, 0, 1);

    // Dual-pixel good frame.
    frame(4, -1, 0); pulse("p6", 1, 1); chk_frame("fE", 0, 5, 0, 8, 4, 48, 10, 0, 1);

    // Dual-pixel frame with a one-clock link glitch in the blanking.
    frame(4, -1, 1);

    // Next frame's first pixel coincides with the vsync edge.
    drive(0, 1, 0);
    drive(0, 0, 0);
    link = 1'b0;
    drive(1, 0, 1);
    check_eq("p7_done_early", 32'(fd_n), 32'(0));
    drive(1, 0, 1);
    check_eq("p7_done", 32'(fd_n), 32'(1));
    chk_frame("fF", 0, 6, 1, 8, 4, 48, 10, 0, 1);
    drive(0, 0, 1);
    check_eq("p7_done_late", 32'(fd_n), 32'(0));
    repeat (5) drive(0, 0, 1);
    repeat (3) drive(0, 0, 0);
    for (int i = 1; i < NLINES; i++) line(8);
    pulse("p8", 1, 0); chk_frame("fG", 0, 7, 0, 8, 4, 32, 14, 0, 1);

    // Reset in the middle of a frame.
    line(8); line(8);
    rst = 1'b1;
    drive(0, 0, 0);
    check_eq("mid_rst_done", 32'(fd_n), 32'(0));
    chk_frame("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) drive(0, 0, 0);
    pulse("p9", 0, 0);
    frame(8, -1, 0); pulse("p10", 1, 0); chk_frame("fH", 0, 1, 0, 8, 4, 32, 14, 0, 0);
    frame(8, -1, 0); pulse("p11", 1, 0); chk_frame("fI_p", 1, 2, 0, 8, 4, 32, 14, 1, 0);

    // Enable dropped mid-frame: published results hold, lock is lost.
    line(8); line(8);
    en = 1'b0;
    repeat (2) drive(0, 0, 0);
    pulse("p12", 0, 0);
    line(8);
    chk_frame("en_drop_p", 1, 2, 0, 8, 4, 32, 14, 0, 0);
    check_eq("en_drop_locked_n", 32'(lk_n), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
